// File: rtl/solver_pkg.sv
// Shared types for the line-solver work queue: entry layout and queue FSM states.
package solver_pkg;
  localparam int SIZE       = 3;
  localparam int ENTRY_W    = SIZE + 1;
  localparam int MARKER_BIT = SIZE;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STUCK = 2'd2,
    ST_DONE  = 2'd3
  } q_state_t;

  typedef struct packed {
    logic            marker;
    logic [SIZE-1:0] data;
  } entry_t;
endpackage

// File: rtl/oq_ring.sv
// Circular entry store with one read port and two ordered write ports.
// Port 0 lands at tail, port 1 right behind it; writes while full are dropped and flagged.
module oq_ring #(
  parameter int W     = 4,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr0_en,
  input  logic [W-1:0]             wr0_data,
  input  logic                     wr1_en,
  input  logic [W-1:0]             wr1_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] wr1_addr;
  logic          acc0;
  logic          acc1;
  logic          rd_ok;
  logic          ovf_set;

  always_comb begin
    acc0     = wr0_en && (count != CW'(DEPTH));
    acc1     = wr1_en && ((count + CW'(acc0)) != CW'(DEPTH));
    rd_ok    = rd_en && (count != '0);
    wr1_addr = tail + AW'(acc0);
    ovf_set  = (wr0_en && !acc0) || (wr1_en && !acc1);
  end

  // Freed slots from a same-edge read are not reusable until the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      head     <= head + AW'(rd_ok);
      tail     <= tail + AW'(acc0) + AW'(acc1);
      count    <= count + CW'(acc0) + CW'(acc1) - CW'(rd_ok);
      overflow <= overflow | ovf_set;
    end
  end

  always_ff @(posedge clk) begin
    if (acc0) mem[tail] <= wr0_data;
    if (acc1) mem[wr1_addr] <= wr1_data;
  end

  assign rd_data = (count != '0) ? mem[head] : '0;
endmodule

// File: rtl/option_queue.sv
// Round-robin work queue for the line solver: loads entries, streams them out,
// recycles markers and kept options, and detects a sweep with no eliminations.
module option_queue
  import solver_pkg::*;
#(
  parameter int SIZE      = solver_pkg::SIZE,
  parameter int DEPTH     = 64,
  parameter int NUM_LINES = 2 * SIZE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_valid,
  input  logic [SIZE:0]                load_entry,
  input  logic                         load_done,
  output logic                         out_valid,
  output logic [SIZE:0]                out_entry,
  input  logic                         out_ready,
  input  logic                         verdict_valid,
  input  logic                         verdict_keep,
  input  logic [SIZE-1:0]              verdict_data,
  input  logic                         solved,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         stuck,
  output logic                         done,
  output logic                         overflow,
  output q_state_t                     state,
  output logic [$clog2(NUM_LINES):0]   sweep
);
  localparam int SW = $clog2(NUM_LINES) + 1;

  q_state_t      state_q, state_d;
  logic [SW-1:0] sweep_q, sweep_d, sweep_inc;
  logic          pop, marker_pop, drop;
  logic          wr0_en;
  logic [SIZE:0] wr0_data;

  oq_ring #(.W(SIZE + 1), .DEPTH(DEPTH)) u_ring (
    .clk      (clk),
    .rst      (rst),
    .wr0_en   (wr0_en),
    .wr0_data (wr0_data),
    .wr1_en   (marker_pop),
    .wr1_data (out_entry),
    .rd_en    (pop),
    .rd_data  (out_entry),
    .count    (count),
    .overflow (overflow)
  );

  // Handshake: the head transfers on any edge where out_valid && out_ready;
  // out_entry is the head itself, so a new head is presented with no bubble.
  always_comb begin
    out_valid  = (state_q == ST_RUN) && (count != '0);
    pop        = out_valid && out_ready;
    marker_pop = pop && out_entry[SIZE];
    drop       = (state_q == ST_RUN) && verdict_valid && !verdict_keep;
    wr0_en     = 1'b0;
    wr0_data   = '0;
    case (state_q)
      ST_LOAD: begin
        wr0_en   = load_valid;
        wr0_data = load_entry;
      end
      ST_RUN: begin
        wr0_en   = verdict_valid && verdict_keep;
        wr0_data = {1'b0, verdict_data};
      end
      default: ;
    endcase

    sweep_inc = sweep_q + SW'(1);
    sweep_d   = sweep_q;
    if (drop)            sweep_d = marker_pop ? SW'(1) : '0;
    else if (marker_pop) sweep_d = sweep_inc;

    state_d = state_q;
    case (state_q)
      ST_LOAD:  if (load_done) state_d = ST_RUN;
      ST_RUN: begin
        if (solved) state_d = ST_DONE;
        else if (marker_pop && !drop && sweep_inc == SW'(NUM_LINES)) state_d = ST_STUCK;
      end
      ST_STUCK: if (solved) state_d = ST_DONE;
      default:  state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  assign state = state_q;
  assign sweep = sweep_q;
  assign stuck = (state_q == ST_STUCK);
  assign done  = (state_q == ST_DONE);
endmodule

// File: tb/tb_option_queue.sv
// Directed bench for option_queue: a DEPTH=64 instance plus a DEPTH=4 instance
// sharing the same stimulus for the full-queue cases.
module tb_option_queue;
  import solver_pkg::*;

  logic       clk = 1'b0;
  logic       rst, load_valid, load_done, out_ready, verdict_valid, verdict_keep, solved;
  logic [3:0] load_entry;
  logic [2:0] verdict_data;

  logic       out_valid, stuck, done, overflow;
  logic [3:0] out_entry;
  logic [6:0] count;
  q_state_t   state;
  logic [3:0] sweep;

  logic       out_valid4, stuck4, done4, overflow4;
  logic [3:0] out_entry4;
  logic [2:0] count4;
  q_state_t   state4;
  logic [3:0] sweep4;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  option_queue #(.SIZE(3), .DEPTH(64)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_entry(load_entry),
    .load_done(load_done), .out_valid(out_valid), .out_entry(out_entry),
    .out_ready(out_ready), .verdict_valid(verdict_valid), .verdict_keep(verdict_keep),
    .verdict_data(verdict_data), .solved(solved), .count(count), .stuck(stuck),
    .done(done), .overflow(overflow), .state(state), .sweep(sweep)
  );

  option_queue #(.SIZE(3), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_entry(load_entry),
    .load_done(load_done), .out_valid(out_valid4), .out_entry(out_entry4),
    .out_ready(out_ready), .verdict_valid(verdict_valid), .verdict_keep(verdict_keep),
    .verdict_data(verdict_data), .solved(solved), .count(count4), .stuck(stuck4),
    .done(done4), .overflow(overflow4), .state(state4), .sweep(sweep4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    load_valid = 0; load_entry = '0; load_done = 0; out_ready = 0;
    verdict_valid = 0; verdict_keep = 0; verdict_data = '0; solved = 0;
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic load(input logic [3:0] e, input logic last);
    load_valid = 1; load_entry = e; load_done = last;
    tick();
    load_valid = 0; load_done = 0;
  endtask

  task automatic load_markers();
    logic [2:0] idx;
    for (int i = 0; i < 6; i++) begin
      idx = i[2:0];
      load({1'b1, idx}, i == 5);
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    vectors++; if (out_entry !== 4'b0) begin errors++; $display("FAIL rst_out_entry got %b want 0000", out_entry); end
    vectors++; if (count !== 7'd0) begin errors++; $display("FAIL rst_count got %0d want 0", count); end
    vectors++; if ({stuck, done, overflow} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b want 000", {stuck, done, overflow}); end
    vectors++; if (state !== ST_LOAD) begin errors++; $display("FAIL rst_state got %0d want %0d", state, ST_LOAD); end
    vectors++; if (sweep !== 4'd0) begin errors++; $display("FAIL rst_sweep got %0d want 0", sweep); end
  endtask

  task automatic test_order();
    do_reset();
    load(4'b1000, 0);
    load(4'b0011, 0);
    load(4'b0110, 1);
    vectors++; if (state !== ST_RUN) begin errors++; $display("FAIL ord_state got %0d want %0d", state, ST_RUN); end
    vectors++; if (count !== 7'd3) begin errors++; $display("FAIL ord_count0 got %0d want 3", count); end
    vectors++; if (out_valid !== 1'b1 || out_entry !== 4'b1000) begin errors++; $display("FAIL ord_head0 got v=%b %b want v=1 1000", out_valid, out_entry); end
    out_ready = 1;
    tick();
    vectors++; if (out_entry !== 4'b0011 || count !== 7'd3) begin errors++; $display("FAIL ord_head1 got %b cnt=%0d want 0011 cnt=3", out_entry, count); end
    tick();
    vectors++; if (out_entry !== 4'b0110 || count !== 7'd2) begin errors++; $display("FAIL ord_head2 got %b cnt=%0d want 0110 cnt=2", out_entry, count); end
    tick();
    out_ready = 0;
    vectors++; if (out_entry !== 4'b1000 || count !== 7'd1) begin errors++; $display("FAIL ord_recycled got %b cnt=%0d want 1000 cnt=1", out_entry, count); end
    vectors++; if (sweep !== 4'd1) begin errors++; $display("FAIL ord_sweep got %0d want 1", sweep); end
  endtask

  task automatic test_same_edge();
    do_reset();
    load(4'b1010, 1);
    vectors++; if (count !== 7'd1 || out_entry !== 4'b1010) begin errors++; $display("FAIL se_pre got %b cnt=%0d want 1010 cnt=1", out_entry, count); end
    out_ready = 1; verdict_valid = 1; verdict_keep = 1; verdict_data = 3'b101;
    tick();
    verdict_valid = 0;
    vectors++; if (count !== 7'd2 || out_entry !== 4'b0101) begin errors++; $display("FAIL se_verdict_first got %b cnt=%0d want 0101 cnt=2", out_entry, count); end
    tick();
    out_ready = 0;
    vectors++; if (count !== 7'd1 || out_entry !== 4'b1010) begin errors++; $display("FAIL se_marker_second got %b cnt=%0d want 1010 cnt=1", out_entry, count); end
  endtask

  task automatic test_stuck();
    do_reset();
    load_markers();
    out_ready = 1;
    repeat (5) tick();
    vectors++; if (sweep !== 4'd5 || stuck !== 1'b0) begin errors++; $display("FAIL stk_pre sweep=%0d stuck=%b want 5 0", sweep, stuck); end
    vectors++; if (out_entry !== 4'b1101) begin errors++; $display("FAIL stk_head5 got %b want 1101", out_entry); end
    tick();
    vectors++; if (stuck !== 1'b1 || state !== ST_STUCK) begin errors++; $display("FAIL stk_assert stuck=%b state=%0d want 1 %0d", stuck, state, ST_STUCK); end
    vectors++; if (out_valid !== 1'b0 || count !== 7'd6) begin errors++; $display("FAIL stk_halt v=%b cnt=%0d want 0 6", out_valid, count); end
    verdict_valid = 1; verdict_keep = 1; verdict_data = 3'b111;
    tick();
    verdict_valid = 0; out_ready = 0;
    vectors++; if (count !== 7'd6 || stuck !== 1'b1) begin errors++; $display("FAIL stk_ignore cnt=%0d stuck=%b want 6 1", count, stuck); end
  endtask

  task automatic test_drop_same_edge();
    do_reset();
    load_markers();
    out_ready = 1;
    repeat (5) tick();
    verdict_valid = 1; verdict_keep = 0; verdict_data = 3'b001;
    tick();
    out_ready = 0; verdict_valid = 0;
    vectors++; if (sweep !== 4'd1) begin errors++; $display("FAIL drp_sweep got %0d want 1", sweep); end
    vectors++; if (stuck !== 1'b0 || state !== ST_RUN) begin errors++; $display("FAIL drp_state stuck=%b state=%0d want 0 %0d", stuck, state, ST_RUN); end
    vectors++; if (count !== 7'd6) begin errors++; $display("FAIL drp_count got %0d want 6", count); end
    verdict_valid = 1;
    tick();
    verdict_valid = 0;
    vectors++; if (sweep !== 4'd0 || count !== 7'd6) begin errors++; $display("FAIL drp_clear sweep=%0d cnt=%0d want 0 6", sweep, count); end
  endtask

  task automatic test_overflow();
    logic [3:0] exp4 [4];
    exp4[0] = 4'b0001; exp4[1] = 4'b0010; exp4[2] = 4'b0011; exp4[3] = 4'b0100;
    do_reset();
    for (int i = 0; i < 4; i++) load(exp4[i], 0);
    vectors++; if (count4 !== 3'd4 || overflow4 !== 1'b0) begin errors++; $display("FAIL ovf_full cnt=%0d ovf=%b want 4 0", count4, overflow4); end
    load(4'b0101, 1);
    vectors++; if (count4 !== 3'd4 || overflow4 !== 1'b1) begin errors++; $display("FAIL ovf_set cnt=%0d ovf=%b want 4 1", count4, overflow4); end
    vectors++; if (overflow !== 1'b0 || count !== 7'd5) begin errors++; $display("FAIL ovf_big ovf=%b cnt=%0d want 0 5", overflow, count); end
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      vectors++; if (out_entry4 !== exp4[i]) begin errors++; $display("FAIL ovf_pop%0d got %b want %b", i, out_entry4, exp4[i]); end
      tick();
    end
    out_ready = 0;
    vectors++; if (count4 !== 3'd0 || out_valid4 !== 1'b0) begin errors++; $display("FAIL ovf_drained cnt=%0d v=%b want 0 0", count4, out_valid4); end
    verdict_valid = 1; verdict_keep = 1; verdict_data = 3'b111;
    tick();
    verdict_valid = 0;
    vectors++; if (out_valid4 !== 1'b1 || out_entry4 !== 4'b0111 || count4 !== 3'd1) begin errors++; $display("FAIL ovf_refill v=%b %b cnt=%0d want 1 0111 1", out_valid4, out_entry4, count4); end
    vectors++; if (overflow4 !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow4); end
  endtask

  task automatic test_solved_and_reset();
    do_reset();
    load(4'b1000, 1);
    solved = 1;
    tick();
    solved = 0;
    vectors++; if (done !== 1'b1 || state !== ST_DONE || out_valid !== 1'b0) begin errors++; $display("FAIL sol_done done=%b state=%0d v=%b want 1 %0d 0", done, state, out_valid, ST_DONE); end
    tick();
    vectors++; if (done !== 1'b1) begin errors++; $display("FAIL sol_hold got %b want 1", done); end
    do_reset();
    load(4'b0011, 0);
    load(4'b1001, 1);
    out_ready = 1;
    tick();
    out_ready = 0;
    vectors++; if (count !== 7'd1) begin errors++; $display("FAIL mid_pre cnt=%0d want 1", count); end
    rst = 1;
    tick();
    rst = 0;
    vectors++; if (count !== 7'd0 || state !== ST_LOAD || out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst cnt=%0d state=%0d v=%b want 0 %0d 0", count, state, out_valid, ST_LOAD); end
    vectors++; if (sweep !== 4'd0 || done !== 1'b0) begin errors++; $display("FAIL mid_rst_sweep sweep=%0d done=%b want 0 0", sweep, done); end
  endtask

  initial begin
    test_reset();
    test_order();
    test_same_edge();
    test_stuck();
    test_drop_same_edge();
    test_overflow();
    test_solved_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
